// File: rtl/tt_mult_pkg.sv
// Shared definitions for the ternary multiplier feeder: FSM state encoding,
// default derived sizes and the 2-bit ternary weight codes.
package tt_mult_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        FILL   = 2'd2,
        BURST  = 2'd3
    } feeder_state_t;

    // Sizes for the default geometry (InLen=16, OutLen=8, BitWidth=8)
    localparam int NUM_W_BYTES = 32;
    localparam int VEC_BYTES   = 16;
    localparam int NUM_ROWS    = 8;

    // Ternary weight encoding; 2'b10 would be a "negative zero" and is illegal
    localparam logic [1:0] T_ZERO = 2'b00;
    localparam logic [1:0] T_POS  = 2'b01;
    localparam logic [1:0] T_NEG  = 2'b11;
    localparam logic [1:0] T_ILL  = 2'b10;

endpackage

// File: rtl/ternary_byte_sanitizer.sv
// Cleans one byte of four packed ternary weights: every illegal code is
// replaced by zero and reported on the illegal flag. Purely combinational.
module ternary_byte_sanitizer
    import tt_mult_pkg::*;
(
    input  logic [7:0] raw,
    output logic [7:0] clean,
    output logic       illegal
);

    // Replace each illegal 2-bit code by zero and flag that one was seen
    always_comb begin
        clean   = raw;
        illegal = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (raw[2*i +: 2] == T_ILL) begin
                clean[2*i +: 2] = T_ZERO;
                illegal         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_feeder.sv
// Upstream feeder for the ternary matrix-vector multiplier.
// Loads the packed ternary weight matrix from a byte stream, buffers one input
// vector and then bursts it into the multiplier one element pair per clock,
// pulsing en in the cycle after each completed burst.
// Optional feature macro: TERNARY_CHECK_EN (sanitize weight bytes, drive err).
module mult_feeder
    import tt_mult_pkg::*;
#(
    parameter int InLen    = 16,
    parameter int OutLen   = 8,
    parameter int BitWidth = 8
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_load,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [2*InLen*OutLen-1:0] W,
    output logic [2*BitWidth-1:0]     vec_in,
    output logic [2:0]                row,
    output logic                      en,
    output logic                      w_valid,
    output logic                      err
);

    localparam int WBits     = 2 * InLen * OutLen;
    localparam int NumWBytes = WBits / 8;
    localparam int VecBytes  = InLen;
    localparam int NumRows   = InLen / 2;
    localparam int CntW      = $clog2(NumWBytes);
    localparam int VbW       = $clog2(VecBytes);

    feeder_state_t state_q, next_state;

    logic [CntW-1:0]     cnt_q;
    logic [WBits-1:0]    w_q;
    logic [2*BitWidth-1:0] vec_q;
    logic [2:0]          row_q;
    logic                en_q;
    logic                in_ready_q;
    logic                w_valid_q;
    logic [BitWidth-1:0] vbuf [VecBytes];

    logic                in_ready_d;
    logic                en_d;
    logic [7:0]          w_byte;
    logic                restart;
    logic                take;
    logic                accepted_load;
    logic [2:0]          next_row;
    logic                last_w_byte;
    logic                last_v_byte;
    logic                last_row;

    // A reload from FILL is only honoured before the first vector byte, and it
    // wins over a byte offered in the same cycle
    assign restart       = (state_q == FILL) && cmd_load && (cnt_q == '0);
    assign take          = in_valid && in_ready_q && !restart;
    assign accepted_load = ((state_q == IDLE) && cmd_load) || restart;
    assign next_row      = row_q + 3'd1;
    assign last_w_byte   = (cnt_q == CntW'(NumWBytes - 1));
    assign last_v_byte   = (cnt_q == CntW'(VecBytes - 1));
    assign last_row      = (row_q == 3'(NumRows - 1));

`ifdef TERNARY_CHECK_EN
    logic illegal;
    logic err_q;

    ternary_byte_sanitizer u_sanitizer (
        .raw     (in_data),
        .clean   (w_byte),
        .illegal (illegal)
    );

    // Sticky illegal-weight flag, cleared only by a new load command
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (accepted_load)
            err_q <= 1'b0;
        else if ((state_q == LOAD_W) && take && illegal)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign w_byte = in_data;
    assign err    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:   if (cmd_load) next_state = LOAD_W;
            LOAD_W: if (take && last_w_byte) next_state = FILL;
            FILL: begin
                if (restart)
                    next_state = LOAD_W;
                else if (take && last_v_byte)
                    next_state = BURST;
            end
            BURST:  if (last_row) next_state = FILL;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered control outputs
    always_comb begin
        in_ready_d = (next_state == LOAD_W) || (next_state == FILL);
        en_d       = (state_q == BURST) && last_row;
    end

    // Counters, weight register, vector pair and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            w_q        <= '0;
            vec_q      <= '0;
            row_q      <= '0;
            en_q       <= 1'b0;
            in_ready_q <= 1'b0;
            w_valid_q  <= 1'b0;
        end else begin
            en_q       <= en_d;
            in_ready_q <= in_ready_d;
            case (state_q)
                IDLE: begin
                    if (cmd_load) begin
                        cnt_q     <= '0;
                        w_valid_q <= 1'b0;
                    end
                end
                LOAD_W: begin
                    if (take) begin
                        w_q[cnt_q*8 +: 8] <= w_byte;
                        if (last_w_byte) begin
                            cnt_q     <= '0;
                            w_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (restart) begin
                        cnt_q     <= '0;
                        w_valid_q <= 1'b0;
                    end else if (take) begin
                        if (last_v_byte) begin
                            cnt_q <= '0;
                            row_q <= '0;
                            vec_q <= {vbuf[1], vbuf[0]};
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (last_row) begin
                        row_q <= '0;
                        cnt_q <= '0;
                    end else begin
                        row_q <= next_row;
                        vec_q <= {vbuf[VbW'({next_row, 1'b1})],
                                  vbuf[VbW'({next_row, 1'b0})]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Vector byte buffer; contents are don't-care until filled
    always_ff @(posedge clk) begin
        if ((state_q == FILL) && take)
            vbuf[cnt_q[VbW-1:0]] <= in_data;
    end

    assign in_ready = in_ready_q;
    assign W        = w_q;
    assign vec_in   = vec_q;
    assign row      = row_q;
    assign en       = en_q;
    assign w_valid  = w_valid_q;

endmodule

// File: tb/tb_mult_feeder.sv
// Directed self-checking bench for mult_feeder (default geometry).
module tb_mult_feeder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_load;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] W;
    logic [15:0]  vec_in;
    logic [2:0]   row;
    logic         en;
    logic         w_valid;
    logic         err;

    int checks = 0;
    int errors = 0;

    mult_feeder #(.InLen(16), .OutLen(8), .BitWidth(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_load (cmd_load),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .W        (W),
        .vec_in   (vec_in),
        .row      (row),
        .en       (en),
        .w_valid  (w_valid),
        .err      (err)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // What the feeder is expected to store for a given weight byte
    function automatic logic [7:0] model_store(input logic [7:0] b);
        logic [7:0] r;
        r = b;
`ifdef TERNARY_CHECK_EN
        for (int i = 0; i < 4; i++)
            if (r[2*i +: 2] == 2'b10) r[2*i +: 2] = 2'b00;
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_load();
        cmd_load = 1'b1;
        step();
        cmd_load = 1'b0;
    endtask

    // Offer one byte and hold it until the feeder takes it (bounded wait)
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("[TB] FAIL send_timeout: in_ready=%0b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (W !== '0)       begin errors++; $display("[TB] FAIL reset_W: got %h expected 0", W); end
        checks++; if (vec_in !== '0)  begin errors++; $display("[TB] FAIL reset_vec_in: got %h expected 0", vec_in); end
        checks++; if (row !== '0)     begin errors++; $display("[TB] FAIL reset_row: got %0d expected 0", row); end
        checks++; if (en !== 1'b0)    begin errors++; $display("[TB] FAIL reset_en: got %b expected 0", en); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (w_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_w_valid: got %b expected 0", w_valid); end
        checks++; if (err !== 1'b0)   begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_in_ready: got %b expected 0", in_ready); end
    endtask

    // Full 32-byte weight load: either a constant byte or base+k
    task automatic test_load(input logic [7:0] base, input bit fixed, input bit gaps, input bit do_pulse);
        logic [255:0] exp_w;
        logic [7:0]   b;
        exp_w = '0;
        if (do_pulse) pulse_load();
        checks++; if (w_valid !== 1'b0)  begin errors++; $display("[TB] FAIL load_start_w_valid: got %b expected 0", w_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL load_start_in_ready: got %b expected 1", in_ready); end
        for (int k = 0; k < 32; k++) begin
            b = fixed ? base : base + 8'(k);
            exp_w[8*k +: 8] = model_store(b);
            if (gaps) idle($urandom_range(0, 2));
            if (k == 31) begin
                checks++; if (w_valid !== 1'b0) begin errors++; $display("[TB] FAIL w_valid_early: got %b expected 0", w_valid); end
            end
            send_byte(b);
        end
        checks++; if (w_valid !== 1'b1)  begin errors++; $display("[TB] FAIL w_valid_done: got %b expected 1", w_valid); end
        checks++; if (W !== exp_w)       begin errors++; $display("[TB] FAIL load_W: got %h expected %h", W, exp_w); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_in_ready: got %b expected 1", in_ready); end
    endtask

    // Fill 16 bytes base+j, then check the 8-cycle burst and the en cycle
    task automatic test_burst(input logic [7:0] base, input bit gaps, input int load_at, input bit burst_load);
        logic [15:0] expv;
        logic [7:0]  lo;
        for (int j = 0; j < 16; j++) begin
            if (gaps) idle($urandom_range(0, 2));
            if (j == load_at) cmd_load = 1'b1;
            send_byte(base + 8'(j));
            cmd_load = 1'b0;
        end
        for (int r = 0; r < 8; r++) begin
            lo   = base + 8'(2*r);
            expv = {lo + 8'd1, lo};
            checks++; if (row !== 3'(r) || vec_in !== expv)
                begin errors++; $display("[TB] FAIL burst_row_vec: got row=%0d vec=%h expected row=%0d vec=%h", row, vec_in, r, expv); end
            checks++; if (in_ready !== 1'b0 || en !== 1'b0)
                begin errors++; $display("[TB] FAIL burst_ready_en: got in_ready=%b en=%b expected 0 0", in_ready, en); end
            cmd_load = burst_load;
            in_data  = 8'hEE;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        cmd_load = 1'b0;
        expv = {base + 8'd15, base + 8'd14};
        checks++; if (en !== 1'b1 || row !== 3'd0)
            begin errors++; $display("[TB] FAIL en_cycle: got en=%b row=%0d expected 1 0", en, row); end
        checks++; if (vec_in !== expv) begin errors++; $display("[TB] FAIL vec_hold: got %h expected %h", vec_in, expv); end
        checks++; if (in_ready !== 1'b1 || w_valid !== 1'b1)
            begin errors++; $display("[TB] FAIL after_burst: got in_ready=%b w_valid=%b expected 1 1", in_ready, w_valid); end
        step();
        checks++; if (en !== 1'b0) begin errors++; $display("[TB] FAIL en_single: got %b expected 0", en); end
    endtask

    task automatic test_reset_abort();
        pulse_load();
        for (int k = 0; k < 20; k++) send_byte(8'h55);
        rst_n = 1'b0;
        step();
        checks++; if (W !== '0 || vec_in !== '0)
            begin errors++; $display("[TB] FAIL abort_data: got W=%h vec=%h expected 0", W, vec_in); end
        checks++; if (row !== '0 || en !== 1'b0 || in_ready !== 1'b0 || w_valid !== 1'b0 || err !== 1'b0)
            begin errors++; $display("[TB] FAIL abort_ctrl: got row=%0d en=%b rdy=%b wv=%b err=%b expected all 0", row, en, in_ready, w_valid, err); end
        rst_n = 1'b1;
        step();
        test_load(8'hAA, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_cmd_load_fill();
        cmd_load = 1'b1;
        in_data  = 8'h99;
        in_valid = 1'b1;
        step();
        cmd_load = 1'b0;
        in_valid = 1'b0;
        test_load(8'h40, 1'b0, 1'b0, 1'b0);
        test_burst(8'h60, 1'b0, 5, 1'b1);
    endtask

    task automatic test_sanitizer();
        logic       exp_err;
        logic [7:0] exp_b;
`ifdef TERNARY_CHECK_EN
        exp_err = 1'b1;
        exp_b   = 8'h34;
`else
        exp_err = 1'b0;
        exp_b   = 8'hB6;
`endif
        pulse_load();
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared_by_load: got %b expected 0", err); end
        send_byte(8'hB6);
        checks++; if (err !== exp_err)  begin errors++; $display("[TB] FAIL err_set: got %b expected %b", err, exp_err); end
        checks++; if (W[7:0] !== exp_b) begin errors++; $display("[TB] FAIL sanitized_byte: got %h expected %h", W[7:0], exp_b); end
        for (int k = 1; k < 32; k++) send_byte(8'h00);
        checks++; if (err !== exp_err || w_valid !== 1'b1)
            begin errors++; $display("[TB] FAIL err_sticky: got err=%b w_valid=%b expected %b 1", err, w_valid, exp_err); end
        pulse_load();
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear: got %b expected 0", err); end
    endtask

    initial begin
        rst_n    = 1'b0;
        cmd_load = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        step();
        step();
        test_reset();
        test_load(8'h00, 1'b0, 1'b0, 1'b1);
        test_burst(8'h10, 1'b0, -1, 1'b0);
        test_load(8'h00, 1'b0, 1'b1, 1'b1);
        test_burst(8'h10, 1'b1, -1, 1'b0);
        test_reset_abort();
        test_cmd_load_fill();
        test_sanitizer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
